// File: rtl/mul_arb_seq.sv
// Purpose: round-robin arbitrated sequential shift-add signed multiplier (magnitude/sign operands).
// Latency: grant at E0, WIDTH iterations, Done/Ack pulse in the cycle after E_WIDTH; one op per WIDTH+2 cycles.
// Backpressure: requesters hold Req level until their Ack bit; no new grant while Busy.
//
// Ports:
//   clk_i, rst_ni              clock, synchronous active-low reset
//   req_i[1:0]                 per-requester level request
//   a0_i/b0_i, a1_i/b1_i       unsigned operand magnitudes of requesters 0 and 1
//   sign_a_i/sign_b_i[1:0]     operand signs, bit i belongs to requester i (1 = negative)
//   busy_o, done_o, ack_o      status, one-cycle result pulse, one-hot Ack of the served requester
//   done_id_o, out_o, ovf_o    served requester, low WIDTH product bits, signed overflow (held until next Done)
module mul_arb_seq #(
  parameter int WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [1:0]       req_i,
  input  logic [WIDTH-1:0] a0_i,
  input  logic [WIDTH-1:0] b0_i,
  input  logic [WIDTH-1:0] a1_i,
  input  logic [WIDTH-1:0] b1_i,
  input  logic [1:0]       sign_a_i,
  input  logic [1:0]       sign_b_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [1:0]       ack_o,
  output logic             done_id_o,
  output logic [WIDTH-1:0] out_o,
  output logic             ovf_o
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_ITER = CW'(WIDTH - 1);
  // 2^(WIDTH-1) and 2^(WIDTH-1)-1 as 2*WIDTH-bit magnitudes
  localparam logic [2*WIDTH-1:0] HALF    = {{WIDTH{1'b0}}, 1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [2*WIDTH-1:0] HALF_M1 = {{(WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic               last_q, last_d;
  logic               id_q, id_d;
  logic               neg_q, neg_d;
  logic [2*WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0]   mplier_q, mplier_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic               done_id_q, done_id_d;
  logic [WIDTH-1:0]   out_q, out_d;
  logic               ovf_q, ovf_d;

  logic               gnt;
  logic [2*WIDTH-1:0] acc_nxt;

  // With both requesting, serve the one that was not served last.
  always_comb begin
    if (req_i == 2'b11) gnt = ~last_q;
    else                gnt = req_i[1];
  end

  always_comb begin
    state_d   = state_q;
    last_d    = last_q;
    id_d      = id_q;
    neg_d     = neg_q;
    mcand_d   = mcand_q;
    mplier_d  = mplier_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    done_id_d = done_id_q;
    out_d     = out_q;
    ovf_d     = ovf_q;
    acc_nxt   = mplier_q[0] ? (acc_q + mcand_q) : acc_q;

    case (state_q)
      IDLE: begin
        if (|req_i) begin
          state_d  = RUN;
          id_d     = gnt;
          last_d   = gnt;
          mcand_d  = {{WIDTH{1'b0}}, (gnt ? a1_i : a0_i)};
          mplier_d = gnt ? b1_i : b0_i;
          neg_d    = sign_a_i[gnt] ^ sign_b_i[gnt];
          acc_d    = '0;
          cnt_d    = '0;
        end
      end
      RUN: begin
        acc_d    = acc_nxt;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + CW'(1);
        if (cnt_q == LAST_ITER) begin
          // Final product is acc_nxt; register the signed result so it is
          // valid throughout the DONE cycle and held afterwards.
          state_d   = DONE;
          done_id_d = id_q;
          out_d     = neg_q ? ((~acc_nxt[WIDTH-1:0]) + WIDTH'(1)) : acc_nxt[WIDTH-1:0];
          ovf_d     = neg_q ? (acc_nxt > HALF) : (acc_nxt > HALF_M1);
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q   <= IDLE;
      last_q    <= 1'b1;
      id_q      <= 1'b0;
      neg_q     <= 1'b0;
      mcand_q   <= '0;
      mplier_q  <= '0;
      acc_q     <= '0;
      cnt_q     <= '0;
      done_id_q <= 1'b0;
      out_q     <= '0;
      ovf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      last_q    <= last_d;
      id_q      <= id_d;
      neg_q     <= neg_d;
      mcand_q   <= mcand_d;
      mplier_q  <= mplier_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      done_id_q <= done_id_d;
      out_q     <= out_d;
      ovf_q     <= ovf_d;
    end
  end

  assign busy_o    = (state_q != IDLE);
  assign done_o    = (state_q == DONE);
  assign ack_o     = (state_q == DONE) ? (done_id_q ? 2'b10 : 2'b01) : 2'b00;
  assign done_id_o = done_id_q;
  assign out_o     = out_q;
  assign ovf_o     = ovf_q;

endmodule

// File: tb/tb_mul_arb_seq.sv
// Purpose: bench for mul_arb_seq against an integer-arithmetic reference model.
// Latency: expects Done sampled WIDTH+1 edges after the request is applied.
// Backpressure: the bench drops the served requester's Req right after seeing Ack.
module tb_mul_arb_seq;
  localparam int W = 8;

  logic         clk;
  logic         rst_n;
  logic [1:0]   req;
  logic [W-1:0] a0, b0, a1, b1;
  logic [1:0]   sa, sb;
  logic         busy, done, done_id, ovf;
  logic [1:0]   ack;
  logic [W-1:0] out;

  int  vectors;
  int  miscompares;
  bit  last_m;   // reference round-robin pointer

  mul_arb_seq #(.WIDTH(W)) dut (
    .clk_i    (clk),
    .rst_ni   (rst_n),
    .req_i    (req),
    .a0_i     (a0),
    .b0_i     (b0),
    .a1_i     (a1),
    .b1_i     (b1),
    .sign_a_i (sa),
    .sign_b_i (sb),
    .busy_o   (busy),
    .done_o   (done),
    .ack_o    (ack),
    .done_id_o(done_id),
    .out_o    (out),
    .ovf_o    (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Apply one request and follow it to completion, checking against the model.
  task automatic do_op(input logic [1:0] rq,
                       input logic [W-1:0] xa0, input logic [W-1:0] xb0,
                       input logic [W-1:0] xa1, input logic [W-1:0] xb1,
                       input logic [1:0] xsa, input logic [1:0] xsb,
                       input bit perturb);
    bit           w;
    int           ma, mb, p, n;
    logic [31:0]  pv;
    logic [W-1:0] eout;
    bit           eovf;
    req = rq; a0 = xa0; b0 = xb0; a1 = xa1; b1 = xb1; sa = xsa; sb = xsb;
    w  = (rq == 2'b11) ? !last_m : rq[1];
    last_m = w;
    ma = w ? int'(xa1) : int'(xa0);
    mb = w ? int'(xb1) : int'(xb0);
    p  = ma * mb;
    if (xsa[w] ^ xsb[w]) p = -p;
    pv   = p;
    eout = pv[W-1:0];
    eovf = (p > (1 << (W-1)) - 1) || (p < -(1 << (W-1)));
    n = 0;
    do begin
      @(negedge clk);
      n++;
      if (n == 1) chk("busy_rise", {31'b0, busy}, 32'd1);
      if (perturb && n == 2) begin
        a0 = W'($urandom); b0 = W'($urandom); a1 = W'($urandom); b1 = W'($urandom);
        sa = ~sa; sb = 2'($urandom);
      end
    end while (!done && n < 3 * W);
    chk("latency", n, W + 1);
    chk("ack", {30'b0, ack}, w ? 32'd2 : 32'd1);
    chk("done_id", {31'b0, done_id}, {31'b0, w});
    chk("out", {24'b0, out}, {24'b0, eout});
    chk("ovf", {31'b0, ovf}, {31'b0, eovf});
    @(negedge clk);
    chk("busy_fall", {31'b0, busy}, 32'd0);
    chk("done_pulse", {31'b0, done}, 32'd0);
    chk("out_hold", {24'b0, out}, {24'b0, eout});
    chk("id_hold", {31'b0, done_id}, {31'b0, w});
    req[w] = 1'b0;
  endtask

  initial begin
    bit seen;
    logic [1:0] r;
    vectors = 0; miscompares = 0; last_m = 1'b1;
    rst_n = 1'b0; req = 2'b11;
    a0 = '0; b0 = '0; a1 = '0; b1 = '0; sa = '0; sb = '0;

    // Reset with both requests asserted
    repeat (2) @(negedge clk);
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_done", {31'b0, done}, 32'd0);
    chk("rst_ack", {30'b0, ack}, 32'd0);
    chk("rst_out", {24'b0, out}, 32'd0);
    chk("rst_ovf", {31'b0, ovf}, 32'd0);
    chk("rst_id", {31'b0, done_id}, 32'd0);
    req = 2'b00; rst_n = 1'b1;
    @(negedge clk);
    chk("idle_busy", {31'b0, busy}, 32'd0);

    // Directed signed cases and overflow boundaries
    do_op(2'b01, 8'd5,   8'd3,   8'd0, 8'd0, 2'b00, 2'b01, 1'b0);
    do_op(2'b01, 8'd16,  8'd8,   8'd0, 8'd0, 2'b00, 2'b00, 1'b0);
    do_op(2'b01, 8'd16,  8'd8,   8'd0, 8'd0, 2'b01, 2'b00, 1'b0);
    do_op(2'b01, 8'd255, 8'd255, 8'd0, 8'd0, 2'b00, 2'b00, 1'b0);
    do_op(2'b01, 8'd0,   8'd77,  8'd0, 8'd0, 2'b01, 2'b00, 1'b0);
    do_op(2'b10, 8'd0,   8'd0,   8'd12, 8'd11, 2'b10, 2'b10, 1'b0);
    // Operands disturbed after grant
    do_op(2'b01, 8'd9,   8'd13,  8'd0, 8'd0, 2'b01, 2'b00, 1'b1);

    // Reset in the middle of RUN
    @(negedge clk);
    req = 2'b01; a0 = 8'd7; b0 = 8'd9; sa = 2'b00; sb = 2'b00;
    repeat (4) @(negedge clk);
    rst_n = 1'b0; req = 2'b00;
    @(negedge clk);
    chk("midrst_busy", {31'b0, busy}, 32'd0);
    chk("midrst_out", {24'b0, out}, 32'd0);
    seen = 1'b0;
    for (int i = 0; i < 12; i++) begin
      seen = seen | done | (|ack);
      if (i == 1) rst_n = 1'b1;
      @(negedge clk);
    end
    chk("midrst_no_done", {31'b0, seen}, 32'd0);
    last_m = 1'b1;

    // Arbitration: both held, requester 0 first, then 1, then 1 alone
    do_op(2'b11, 8'd21, 8'd6, 8'd3, 8'd50, 2'b00, 2'b10, 1'b0);
    do_op(2'b10, 8'd21, 8'd6, 8'd3, 8'd50, 2'b00, 2'b10, 1'b0);
    do_op(2'b10, 8'd21, 8'd6, 8'd4, 8'd31, 2'b10, 2'b00, 1'b0);

    // Randomized operations
    for (int k = 0; k < 40; k++) begin
      r = 2'($urandom_range(1, 3));
      do_op(r, W'($urandom), W'($urandom), W'($urandom), W'($urandom),
            2'($urandom), 2'($urandom), bit'($urandom_range(0, 1)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
